// File: rtl/lcd_cmd_sched.sv
// LCD command scheduler: queues host commands in a small FIFO and issues them
// to an LCD controller with busy guarding, write-back tracking and a watchdog.
module lcd_cmd_sched #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] host_cmd,
  input  logic       host_valid,
  output logic       host_ready,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  input  logic       busy,
  input  logic       done,
  output logic       seq_done,
  output logic       seq_err,
  output logic [7:0] issued_cnt,
  output logic [3:0] fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GUARD,
    S_WAIT_DONE,
    S_ERR
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [3:0]       level;
  logic [7:0]       wdog;
  logic             wd_count;
  logic             wd_expire;
  logic             push;
  logic             pop;

  assign host_ready = !reset && (level < 4'(DEPTH)) && (state != S_ERR);
  assign cmd_valid  = (state == S_ISSUE);
  assign seq_err    = (state == S_ERR);
  assign fifo_level = level;

  // a push that coincides with the error transition is discarded with the flush
  assign pop  = (state == S_ISSUE);
  assign push = host_valid && host_ready && (state_nxt != S_ERR);

  always_comb begin
    state_nxt = state;
    wd_count  = ((state == S_GUARD) && busy) || ((state == S_WAIT_DONE) && !done);
    wd_expire = wd_count && (wdog == 8'(TIMEOUT - 1));
    case (state)
      S_IDLE:      if (level != 4'd0 && !busy) state_nxt = S_ISSUE;
      S_ISSUE:     state_nxt = (cmd != 3'd0) ? S_GUARD : S_WAIT_DONE;
      S_GUARD: begin
        if (!busy)          state_nxt = S_IDLE;
        else if (wd_expire) state_nxt = S_ERR;
      end
      S_WAIT_DONE: begin
        if (done)           state_nxt = S_IDLE;
        else if (wd_expire) state_nxt = S_ERR;
      end
      S_ERR:       state_nxt = S_ERR;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      head       <= '0;
      tail       <= '0;
      level      <= 4'd0;
      cmd        <= 3'd0;
      seq_done   <= 1'b0;
      issued_cnt <= 8'd0;
      wdog       <= 8'd0;
    end else begin
      state    <= state_nxt;
      seq_done <= (state == S_WAIT_DONE) && done;
      if (state_nxt != state) wdog <= 8'd0;
      else if (wd_count)      wdog <= wdog + 8'd1;
      if (state_nxt == S_ERR) begin
        head  <= '0;
        tail  <= '0;
        level <= 4'd0;
      end else begin
        if (push) tail <= tail + PTR_W'(1);
        if (pop)  head <= head + PTR_W'(1);
        level <= level + 4'(push) - 4'(pop);
      end
      // cmd is captured as the head enters ISSUE and then holds until the next issue
      if (state == S_IDLE && state_nxt == S_ISSUE) cmd <= mem[head];
      if (pop) issued_cnt <= issued_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= host_cmd;
  end

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Randomized and directed bench for lcd_cmd_sched against a queue-based model.
module tb_lcd_cmd_sched;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 30;

  localparam int P_READY   = 0;
  localparam int P_ISSUING = 1;
  localparam int P_SETTLE  = 2;
  localparam int P_AWAIT   = 3;
  localparam int P_FAIL    = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] host_cmd;
  logic       host_valid;
  logic       host_ready;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       busy;
  logic       done;
  logic       seq_done;
  logic       seq_err;
  logic [7:0] issued_cnt;
  logic [3:0] fifo_level;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: pending commands, current phase, stall cycles in phase
  int q[$];
  int m_phase = P_READY;
  int m_wait  = 0;
  int m_cmd   = 0;
  int m_cnt   = 0;
  bit m_sdone = 1'b0;

  lcd_cmd_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .host_cmd  (host_cmd),
    .host_valid(host_valid),
    .host_ready(host_ready),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .busy      (busy),
    .done      (done),
    .seq_done  (seq_done),
    .seq_err   (seq_err),
    .issued_cnt(issued_cnt),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return !reset && (q.size() < DEPTH) && (m_phase != P_FAIL);
  endfunction

  task automatic model_edge();
    bit push;
    bit fail;
    int nphase;
    push    = host_valid && model_ready();
    fail    = 1'b0;
    nphase  = m_phase;
    m_sdone = 1'b0;
    if (reset) begin
      q.delete();
      m_phase = P_READY;
      m_wait  = 0;
      m_cmd   = 0;
      m_cnt   = 0;
      return;
    end
    case (m_phase)
      P_READY: if (q.size() > 0 && !busy) begin
        nphase = P_ISSUING;
        m_cmd  = q[0];
      end
      P_ISSUING: begin
        void'(q.pop_front());
        m_cnt  = (m_cnt + 1) % 256;
        nphase = (m_cmd != 0) ? P_SETTLE : P_AWAIT;
      end
      P_SETTLE: begin
        if (!busy) nphase = P_READY;
        else begin
          m_wait++;
          if (m_wait == TIMEOUT) fail = 1'b1;
        end
      end
      P_AWAIT: begin
        if (done) begin
          nphase  = P_READY;
          m_sdone = 1'b1;
        end else begin
          m_wait++;
          if (m_wait == TIMEOUT) fail = 1'b1;
        end
      end
      default: ;
    endcase
    if (fail) begin
      nphase = P_FAIL;
      q.delete();
    end else if (push) begin
      q.push_back(int'(host_cmd));
    end
    if (nphase != m_phase) m_wait = 0;
    m_phase = nphase;
  endtask

  task automatic compare_outputs();
    check_eq("host_ready", host_ready, model_ready());
    check_eq("cmd",        cmd,        m_cmd);
    check_eq("cmd_valid",  cmd_valid,  m_phase == P_ISSUING);
    check_eq("seq_done",   seq_done,   m_sdone);
    check_eq("seq_err",    seq_err,    m_phase == P_FAIL);
    check_eq("issued_cnt", issued_cnt, m_cnt);
    check_eq("fifo_level", fifo_level, q.size());
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic idle_inputs();
    host_valid = 1'b0;
    host_cmd   = 3'd0;
    busy       = 1'b0;
    done       = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic push_one(input logic [2:0] c);
    host_valid = 1'b1;
    host_cmd   = c;
    cyc();
    host_valid = 1'b0;
  endtask

  initial begin
    int pushed;
    reset = 1'b1;
    idle_inputs();
    do_reset();
    check_eq("rst_cnt",   issued_cnt, 0);
    check_eq("rst_level", fifo_level, 0);
    check_eq("rst_cmd",   cmd, 0);

    // three non-write commands with the controller idle
    push_one(3'd1);
    push_one(3'd3);
    push_one(3'd5);
    repeat (15) cyc();
    check_eq("seq135_cnt",   issued_cnt, 3);
    check_eq("seq135_level", fifo_level, 0);
    check_eq("seq135_last",  cmd, 5);

    // fill the FIFO while busy holds issues off
    do_reset();
    busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      host_valid = 1'b1;
      host_cmd   = 3'(i + 2);
      cyc();
    end
    host_valid = 1'b0;
    check_eq("full_ready", host_ready, 0);
    check_eq("full_level", fifo_level, DEPTH);
    repeat (10) cyc();
    busy = 1'b0;
    repeat (20) cyc();
    check_eq("full_drain_cnt", issued_cnt, DEPTH);

    // write command followed by a queued op, done ten cycles after issue
    do_reset();
    push_one(3'd0);
    push_one(3'd2);
    for (int i = 0; i < 20 && m_phase != P_AWAIT; i++) cyc();
    repeat (9) cyc();
    check_eq("wr_hold_cnt", issued_cnt, 1);
    done = 1'b1;
    cyc();
    done = 1'b0;
    check_eq("wr_seq_done", seq_done, 1);
    cyc();
    check_eq("wr_seq_done_end", seq_done, 0);
    repeat (10) cyc();
    check_eq("wr_next_cnt", issued_cnt, 2);
    check_eq("wr_next_cmd", cmd, 2);

    // write command with no write-back: watchdog error, push at entry dropped
    do_reset();
    push_one(3'd0);
    for (int i = 0; i < TIMEOUT + 20 && m_phase != P_FAIL; i++) begin
      host_valid = (m_phase == P_AWAIT) && (m_wait == TIMEOUT - 1);
      host_cmd   = 3'd6;
      cyc();
    end
    host_valid = 1'b0;
    check_eq("to_err",   seq_err, 1);
    check_eq("to_level", fifo_level, 0);
    check_eq("to_ready", host_ready, 0);
    host_valid = 1'b1;
    host_cmd   = 3'd1;
    repeat (5) cyc();
    host_valid = 1'b0;
    check_eq("to_sticky", seq_err, 1);

    // reset while waiting for write-back with commands queued
    do_reset();
    push_one(3'd0);
    push_one(3'd1);
    push_one(3'd2);
    push_one(3'd3);
    for (int i = 0; i < 20 && m_phase != P_AWAIT; i++) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_eq("mid_rst_level", fifo_level, 0);
    check_eq("mid_rst_cmd",   cmd, 0);
    check_eq("mid_rst_cnt",   issued_cnt, 0);
    repeat (10) cyc();

    // counter wrap after 256 issues, then a stray done in idle
    do_reset();
    pushed = 0;
    for (int i = 0; i < 2000 && pushed < 256; i++) begin
      host_valid = 1'b1;
      host_cmd   = 3'($urandom_range(1, 7));
      if (model_ready()) pushed++;
      cyc();
    end
    host_valid = 1'b0;
    repeat (20) cyc();
    check_eq("wrap_pushed", pushed, 256);
    check_eq("wrap_cnt",    issued_cnt, 0);
    done = 1'b1;
    cyc();
    done = 1'b0;
    cyc();
    check_eq("idle_done", seq_done, 0);

    // randomized traffic with occasional reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      host_valid = $urandom_range(0, 1) != 0;
      host_cmd   = 3'($urandom_range(0, 7));
      busy       = ($urandom_range(0, 3) == 0);
      done       = ($urandom_range(0, 7) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
